ls_p1: RTL
==========

# ls_p1

Second load/store stage. Consumes the decoded access (`ls_func`, effective address, store data, destination tag) from the address-generation stage. Drives a single-outstanding request/grant/rvalid data-memory port, and returns sign/zero-extended load results on a writeback handshake. Back-pressures the address stage through `ready_i` while an access is in flight.

## Interface

Parameters: none. Widths are fixed by `INSTRUCTION_LS`.

Ports:
- `clk` in 1: the only clock.
- `reset` in 1: asynchronous, active-low reset.
- `instruction_i` in `INSTRUCTION_LS`: `ls_func`, `addr[31:0]`, `data[31:0]`, `rd[6:0]`. `LS_NOP` means no access.
- `ready_i` out 1: stage can accept `instruction_i` this cycle.
- `mem_req` out 1: bus request.
- `mem_we` out 1: 1 = store.
- `mem_be` out 4: byte enables.
- `mem_addr` out 32: word-aligned address, `[1:0]` = 0.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_gnt` in 1: request accepted.
- `mem_rvalid` in 1: read data valid.
- `mem_rdata` in 32: read word.
- `wb_valid` out 1: load result available.
- `wb_rd` out 7: destination tag.
- `wb_data` out 32: extended load result.
- `wb_ready` in 1: writeback consumer accepts.
- `misalign_o` out 1: misaligned-access trap pulse.
- `misalign_addr` out 32: faulting byte address.

## Operation

State machine `IDLE`, `REQ`, `RESP`, `WB`, `TRAP`.

- `ready_i` = (state == `IDLE`).
- Accept = `ready_i` && `ls_func` != `LS_NOP`. On accept, latch func/addr/data/rd and go to `REQ`. The exception is a misaligned access when `TRAP` is compiled in; that goes to `TRAP`.
- `REQ`:
  - `mem_req` = 1. Bus outputs stay stable until `mem_gnt`.
  - On gnt: a store goes to `IDLE`; a load goes to `RESP`.
- `RESP`: wait for `mem_rvalid`, register the extracted result, go to `WB`.
- `WB`: `wb_valid` = 1 and holds until `wb_ready`, then go to `IDLE`.
- `TRAP`: `misalign_o` = 1 for exactly one cycle, `misalign_addr` = latched addr, then go to `IDLE`. No bus access and no writeback.
- `mem_gnt` is ignored outside `REQ`. `mem_rvalid` is ignored outside `RESP`.

Byte lanes, with `o` = addr[1:0]:
- SB: be = 1<<o; wdata = {4{data[7:0]}}.
- SH: be = o[1] ? 4'b1100 : 4'b0011; wdata = {2{data[15:0]}}.
- SW: be = 4'b1111; wdata = data.
- Loads: `mem_we` = 0, be = 4'b1111.

Load extraction, with `s` = `mem_rdata` >> (8*o):
- LB: sign-extend s[7:0].
- LBU: zero-extend s[7:0].
- LH: sign-extend s[15:0], shifting by 8*{o[1],1'b0}.
- LHU: zero-extend s[15:0], same shift as LH.
- LW: word as-is.

Misaligned means: halfword with o[0] = 1, or word with o != 0.

Reset values: state `IDLE`; `mem_req` 0, `mem_we` 0, `mem_be` 0, `mem_addr` 0, `mem_wdata` 0; `wb_valid` 0, `wb_rd` 0, `wb_data` 0; `misalign_o` 0, `misalign_addr` 0.

## Timing

- All outputs are registered, except `ready_i`, which decodes state.
- Store: accept at T; `mem_req` at T+1. With gnt at T+1, `ready_i` is high at T+2. Throughput is one store per 2 cycles.
- Load: accept at T; `mem_req` at T+1; gnt at T+1; earliest rvalid at T+2; `wb_valid` at T+3. With `wb_ready` at T+3, `ready_i` is high at T+4.
- Gnt stall: `mem_req` and all bus outputs hold for N cycles.
- `wb_ready` low: `wb_valid`/`wb_rd`/`wb_data` hold and `ready_i` stays 0.
- Upstream holds `instruction_i` while `ready_i` = 0; the stage never samples it then.
- Reset asserted mid-access: `mem_req` and `wb_valid` drop asynchronously and state returns to `IDLE`. A late `mem_rvalid` after reset release is dropped.

## Configuration

`LS_MISALIGN_TRAP_EN`:
- Defined: misaligned accesses take `TRAP` as above.
- Undefined:
  - No `TRAP` state.
  - Misaligned accesses proceed with low address bits truncated to natural alignment: halfword uses o[1] only, word uses o = 0.
  - `misalign_o` and `misalign_addr` are tied to 0.

## Test plan

- SB: addr 0x1003, data 0xA5 -> `mem_addr` 0x1000, be 4'b1000, wdata 0xA5A5A5A5, `mem_we` 1. No `wb_valid`. `ready_i` returns 2 cycles after accept.
- LB then LBU: addr 0x2001, rdata 0x0000_8000 -> LB gives wb_data 0xFFFFFF80, LBU gives 0x00000080, with matching `wb_rd`.
- LH: addr 0x3002, rdata 0x8001_0000 -> wb_data 0xFFFF8001. gnt held low for 3 cycles -> `mem_req`/addr/be stable throughout.
- LW with rvalid 2 cycles after gnt and `wb_ready` low for 2 cycles -> `wb_valid` holds with stable data; `ready_i` stays 0 until the handshake.
- SW at 0x4002 with `LS_MISALIGN_TRAP_EN`: `mem_req` never rises; one-cycle `misalign_o`, `misalign_addr` 0x4002. Without the macro: `mem_addr` 0x4000, be 4'b1111.
- Reset pulse in `RESP`, then `mem_rvalid` arrives: outputs reach reset values immediately, no `wb_valid`, and `ready_i` is 1 after release.

Source files
------------

// File: rtl/ls_p1.sv
// Second load/store stage: one outstanding req/gnt/rvalid data-memory access with load extension and writeback.
// Optional misaligned-access trap is compiled in with `define LS_MISALIGN_TRAP_EN.

package ls_p1_pkg;

   typedef enum logic [3:0] {
      LS_NOP = 4'd0,
      LS_LB  = 4'd1,
      LS_LBU = 4'd2,
      LS_LH  = 4'd3,
      LS_LHU = 4'd4,
      LS_LW  = 4'd5,
      LS_SB  = 4'd6,
      LS_SH  = 4'd7,
      LS_SW  = 4'd8
   } ls_func_e;

   typedef struct packed {
      ls_func_e    ls_func;
      logic [31:0] addr;
      logic [31:0] data;
      logic [6:0]  rd;
   } instruction_ls_t;

endpackage

module ls_p1
   import ls_p1_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  instruction_ls_t instruction_i,
   output logic            ready_i,
   output logic            mem_req,
   output logic            mem_we,
   output logic [3:0]      mem_be,
   output logic [31:0]     mem_addr,
   output logic [31:0]     mem_wdata,
   input  logic            mem_gnt,
   input  logic            mem_rvalid,
   input  logic [31:0]     mem_rdata,
   output logic            wb_valid,
   output logic [6:0]      wb_rd,
   output logic [31:0]     wb_data,
   input  logic            wb_ready,
   output logic            misalign_o,
   output logic [31:0]     misalign_addr,
   output logic [2:0]      dbg_state_o
);

   // Handshakes: instruction_i is taken on a cycle where ready_i is high and ls_func != LS_NOP;
   // mem_req holds with stable bus fields until the cycle mem_gnt is seen; wb_valid holds with
   // stable wb_rd/wb_data until the cycle wb_ready is seen.

`ifdef LS_MISALIGN_TRAP_EN
   typedef enum logic [2:0] {S_IDLE, S_REQ, S_RESP, S_WB, S_TRAP} state_e;
`else
   typedef enum logic [2:0] {S_IDLE, S_REQ, S_RESP, S_WB} state_e;
`endif

   state_e      state_q, state_d;
   ls_func_e    func_q, func_d;
   logic [1:0]  off_q, off_d;
   logic [6:0]  rd_q, rd_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        wb_valid_q, wb_valid_d;
   logic [6:0]  wb_rd_q, wb_rd_d;
   logic [31:0] wb_data_q, wb_data_d;

   ls_func_e    in_func;
   logic        in_is_half, in_is_word, in_is_store;
   logic [1:0]  in_off, in_off_eff;
   logic [3:0]  in_be;
   logic [31:0] in_wdata;
   logic        accept;
   logic [31:0] rdata_shift, load_result;

`ifdef LS_MISALIGN_TRAP_EN
   logic        misalign_q, misalign_d;
   logic [31:0] misalign_addr_q, misalign_addr_d;
   logic        in_misaligned;
`endif

   assign ready_i = (state_q == S_IDLE);
   assign in_func = instruction_i.ls_func;
   assign accept  = ready_i && (in_func != LS_NOP);

   // Offset is truncated to natural alignment so the non-trapping build still lands in-word.
   always_comb begin
      in_off      = instruction_i.addr[1:0];
      in_is_half  = (in_func == LS_LH) || (in_func == LS_LHU) || (in_func == LS_SH);
      in_is_word  = (in_func == LS_LW) || (in_func == LS_SW);
      in_is_store = (in_func == LS_SB) || (in_func == LS_SH) || (in_func == LS_SW);
      if (in_is_word)      in_off_eff = 2'b00;
      else if (in_is_half) in_off_eff = {in_off[1], 1'b0};
      else                 in_off_eff = in_off;
      case (in_func)
         LS_SB: begin
            in_be    = 4'b0001 << in_off;
            in_wdata = {4{instruction_i.data[7:0]}};
         end
         LS_SH: begin
            in_be    = in_off[1] ? 4'b1100 : 4'b0011;
            in_wdata = {2{instruction_i.data[15:0]}};
         end
         LS_SW: begin
            in_be    = 4'b1111;
            in_wdata = instruction_i.data;
         end
         default: begin
            in_be    = 4'b1111;
            in_wdata = 32'h0;
         end
      endcase
   end

`ifdef LS_MISALIGN_TRAP_EN
   assign in_misaligned = (in_is_half && in_off[0]) || (in_is_word && (in_off != 2'b00));
`endif

   always_comb begin
      rdata_shift = mem_rdata >> {off_q, 3'b000};
      case (func_q)
         LS_LB:   load_result = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
         LS_LBU:  load_result = {24'h0, rdata_shift[7:0]};
         LS_LH:   load_result = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
         LS_LHU:  load_result = {16'h0, rdata_shift[15:0]};
         default: load_result = rdata_shift;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      func_d      = func_q;
      off_d       = off_q;
      rd_d        = rd_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_be_d    = mem_be_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      wb_valid_d  = wb_valid_q;
      wb_rd_d     = wb_rd_q;
      wb_data_d   = wb_data_q;
`ifdef LS_MISALIGN_TRAP_EN
      misalign_d      = 1'b0;
      misalign_addr_d = misalign_addr_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               func_d      = in_func;
               off_d       = in_off_eff;
               rd_d        = instruction_i.rd;
               state_d     = S_REQ;
               mem_req_d   = 1'b1;
               mem_we_d    = in_is_store;
               mem_be_d    = in_be;
               mem_addr_d  = {instruction_i.addr[31:2], 2'b00};
               mem_wdata_d = in_wdata;
`ifdef LS_MISALIGN_TRAP_EN
               if (in_misaligned) begin
                  state_d         = S_TRAP;
                  mem_req_d       = 1'b0;
                  misalign_d      = 1'b1;
                  misalign_addr_d = instruction_i.addr;
               end
`endif
            end
         end
         S_REQ: begin
            if (mem_gnt) begin
               mem_req_d = 1'b0;
               state_d   = mem_we_q ? S_IDLE : S_RESP;
            end
         end
         S_RESP: begin
            if (mem_rvalid) begin
               wb_valid_d = 1'b1;
               wb_rd_d    = rd_q;
               wb_data_d  = load_result;
               state_d    = S_WB;
            end
         end
         S_WB: begin
            if (wb_ready) begin
               wb_valid_d = 1'b0;
               state_d    = S_IDLE;
            end
         end
`ifdef LS_MISALIGN_TRAP_EN
         S_TRAP: state_d = S_IDLE;
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         func_q      <= LS_NOP;
         off_q       <= 2'b00;
         rd_q        <= 7'h0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= 4'h0;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
         wb_valid_q  <= 1'b0;
         wb_rd_q     <= 7'h0;
         wb_data_q   <= 32'h0;
      end else begin
         state_q     <= state_d;
         func_q      <= func_d;
         off_q       <= off_d;
         rd_q        <= rd_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         wb_valid_q  <= wb_valid_d;
         wb_rd_q     <= wb_rd_d;
         wb_data_q   <= wb_data_d;
      end
   end

`ifdef LS_MISALIGN_TRAP_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         misalign_q      <= 1'b0;
         misalign_addr_q <= 32'h0;
      end else begin
         misalign_q      <= misalign_d;
         misalign_addr_q <= misalign_addr_d;
      end
   end
   assign misalign_o    = misalign_q;
   assign misalign_addr = misalign_addr_q;
`else
   assign misalign_o    = 1'b0;
   assign misalign_addr = 32'h0;
`endif

   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_be      = mem_be_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign wb_valid    = wb_valid_q;
   assign wb_rd       = wb_rd_q;
   assign wb_data     = wb_data_q;
   assign dbg_state_o = state_q;

endmodule
